// File: rtl/mmio_key_controller.sv
// Memory-mapped PS/2 keyboard controller: scan-code prefix decoder, key-word FIFO,
// status register and RAM pass-through. Define KEY_RELEASE_EN to queue break (release) words.
module mmio_key_controller #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] KEY_ADDR    = ADDR_WIDTH'(24'h3b00),
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(24'h3b01)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            scan_code,
    input  logic                  scan_valid,
    input  logic [DATA_WIDTH-1:0] ram_to_mem_data,
    input  logic [DATA_WIDTH-1:0] core_to_mem_data,
    input  logic [ADDR_WIDTH-1:0] core_to_mem_address,
    input  logic                  core_to_mem_write_enable,
    input  logic                  core_to_mem_read_enable,
    output logic                  mem_to_ram_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_to_ram_address,
    output logic [DATA_WIDTH-1:0] mem_to_ram_data,
    output logic [DATA_WIDTH-1:0] mem_to_core_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    // Reset asserts immediately but is released two clock edges after rst_n rises.
    logic rst_meta;
    logic rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // Returns {hit, make_word}; extended and normal code sets are disjoint.
    function automatic logic [16:0] lookup(input logic [7:0] code, input logic ext);
        lookup = '0;
        if (!ext) begin
            case (code)
                8'h1B:   lookup = {1'b1, 16'hFF53};
                8'h1C:   lookup = {1'b1, 16'hFF41};
                8'h1D:   lookup = {1'b1, 16'hFF57};
                8'h23:   lookup = {1'b1, 16'hFF44};
                default: lookup = '0;
            endcase
        end else begin
            case (code)
                8'h75:   lookup = {1'b1, 16'hFF2F};
                8'h72:   lookup = {1'b1, 16'hFF5C};
                default: lookup = '0;
            endcase
        end
    endfunction

    state_t      state;
    state_t      next_state;
    logic        push;
    logic [15:0] push_word;
    logic [16:0] hit;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= IDLE;
        else             state <= next_state;
    end

    always_comb begin
        next_state = state;
        push       = 1'b0;
        push_word  = '0;
        hit        = '0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == 8'hE0) begin
                        next_state = EXT;
                    end else if (scan_code == 8'hF0) begin
                        next_state = BRK;
                    end else begin
                        hit       = lookup(scan_code, 1'b0);
                        push      = hit[16];
                        push_word = hit[15:0];
                    end
                end
                EXT: begin
                    if (scan_code == 8'hF0) begin
                        next_state = EXT_BRK;
                    end else begin
                        hit        = lookup(scan_code, 1'b1);
                        push       = hit[16];
                        push_word  = hit[15:0];
                        next_state = IDLE;
                    end
                end
                default: begin
                    hit = lookup(scan_code, state == EXT_BRK);
`ifdef KEY_RELEASE_EN
                    push      = hit[16];
                    push_word = {8'hFE, hit[7:0]};
`endif
                    next_state = IDLE;
                end
            endcase
        end
    end

    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             empty;
    logic             full;
    logic             pop;
    logic             do_push;
    logic             ovf_set;
    logic             status_read;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign pop         = core_to_mem_read_enable && (core_to_mem_address == KEY_ADDR) && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_push     = push && (!full || pop);
    assign ovf_set     = push && full && !pop;
    assign status_read = core_to_mem_read_enable && (core_to_mem_address == STATUS_ADDR);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovf_set)          overflow <= 1'b1;
            else if (status_read) overflow <= 1'b0;
        end
    end

    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] key_word;

    always_comb begin
        status_word             = '0;
        status_word[0]          = !empty;
        status_word[1]          = full;
        status_word[2]          = overflow;
        status_word[8 +: CNT_W] = count;
        key_word                = '0;
        if (!empty) key_word[15:0] = mem[rd_ptr];
    end

    always_comb begin
        if (core_to_mem_address == KEY_ADDR)         mem_to_core_data = key_word;
        else if (core_to_mem_address == STATUS_ADDR) mem_to_core_data = status_word;
        else                                         mem_to_core_data = ram_to_mem_data;
    end

    assign mem_to_ram_write_enable = core_to_mem_write_enable &&
                                     (core_to_mem_address != KEY_ADDR) &&
                                     (core_to_mem_address != STATUS_ADDR);
    assign mem_to_ram_address = core_to_mem_address;
    assign mem_to_ram_data    = core_to_mem_data;

endmodule

// File: tb/tb_mmio_key_controller.sv
// Directed bench for mmio_key_controller: decoder, FIFO, status/overflow, write blocking, reset.
module tb_mmio_key_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic [15:0] ram_to_mem_data;
    logic [15:0] core_to_mem_data;
    logic [23:0] core_to_mem_address;
    logic        core_to_mem_write_enable;
    logic        core_to_mem_read_enable;
    logic        mem_to_ram_write_enable;
    logic [23:0] mem_to_ram_address;
    logic [15:0] mem_to_ram_data;
    logic [15:0] mem_to_core_data;

    int total = 0;
    int bad   = 0;

    mmio_key_controller dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .scan_code                (scan_code),
        .scan_valid               (scan_valid),
        .ram_to_mem_data          (ram_to_mem_data),
        .core_to_mem_data         (core_to_mem_data),
        .core_to_mem_address      (core_to_mem_address),
        .core_to_mem_write_enable (core_to_mem_write_enable),
        .core_to_mem_read_enable  (core_to_mem_read_enable),
        .mem_to_ram_write_enable  (mem_to_ram_write_enable),
        .mem_to_ram_address       (mem_to_ram_address),
        .mem_to_ram_data          (mem_to_ram_data),
        .mem_to_core_data         (mem_to_core_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small RAM behind the controller, indexed by the low address byte.
    logic [15:0] ram_model [256];
    initial for (int i = 0; i < 256; i++) ram_model[i] = 16'h0000;
    always @(posedge clk) if (mem_to_ram_write_enable) ram_model[mem_to_ram_address[7:0]] <= mem_to_ram_data;
    assign ram_to_mem_data = ram_model[core_to_mem_address[7:0]];

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        scan_valid = 1'b0;
        core_to_mem_read_enable = 1'b0;
        core_to_mem_write_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] code);
        @(negedge clk);
        scan_code = code;
        scan_valid = 1'b1;
        @(posedge clk);
        #1 scan_valid = 1'b0;
    endtask

    task automatic access(input logic [23:0] addr, input logic en, output logic [15:0] got);
        @(negedge clk);
        core_to_mem_address = addr;
        core_to_mem_read_enable = en;
        #1 got = mem_to_core_data;
        @(posedge clk);
        #1 core_to_mem_read_enable = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        scan(8'h1C);
        @(negedge clk);
        rst_n = 1'b0;
        core_to_mem_address = 24'h3b00;
        #1 got = mem_to_core_data;
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL reset_key got=%h exp=%h", got, 16'h0000); end
        core_to_mem_address = 24'h3b01;
        #1 got = mem_to_core_data;
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h exp=%h", got, 16'h0000); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL post_reset_status got=%h exp=%h", got, 16'h0000); end
    endtask

    task automatic test_basic();
        logic [15:0] got;
        apply_reset();
        scan(8'h1C);
        access(24'h3b00, 1'b0, got);
        total++;
        if (got !== 16'hFF41) begin bad++; $display("FAIL basic_key got=%h exp=%h", got, 16'hFF41); end
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0101) begin bad++; $display("FAIL basic_status got=%h exp=%h", got, 16'h0101); end
        access(24'h3b00, 1'b1, got);
        total++;
        if (got !== 16'hFF41) begin bad++; $display("FAIL basic_pop got=%h exp=%h", got, 16'hFF41); end
        access(24'h3b00, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL basic_key_empty got=%h exp=%h", got, 16'h0000); end
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL basic_status_empty got=%h exp=%h", got, 16'h0000); end
        access(24'h3b00, 1'b1, got);
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL empty_pop_status got=%h exp=%h", got, 16'h0000); end
    endtask

    task automatic test_extended();
        logic [15:0] got;
        apply_reset();
        scan(8'hE0); scan(8'h75);
        scan(8'h75);
        scan(8'hE0); scan(8'h1C);
        scan(8'h72);
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0101) begin bad++; $display("FAIL ext_status got=%h exp=%h", got, 16'h0101); end
        access(24'h3b00, 1'b0, got);
        total++;
        if (got !== 16'hFF2F) begin bad++; $display("FAIL ext_key got=%h exp=%h", got, 16'hFF2F); end
        scan(8'hF0); scan(8'h1B);
        scan(8'hE0); scan(8'hF0); scan(8'h75);
        access(24'h3b01, 1'b0, got);
`ifdef KEY_RELEASE_EN
        total++;
        if (got !== 16'h0301) begin bad++; $display("FAIL break_status got=%h exp=%h", got, 16'h0301); end
        access(24'h3b00, 1'b1, got);
        access(24'h3b00, 1'b1, got);
        total++;
        if (got !== 16'hFE53) begin bad++; $display("FAIL break_word got=%h exp=%h", got, 16'hFE53); end
        access(24'h3b00, 1'b1, got);
        total++;
        if (got !== 16'hFE2F) begin bad++; $display("FAIL ext_break_word got=%h exp=%h", got, 16'hFE2F); end
`else
        total++;
        if (got !== 16'h0101) begin bad++; $display("FAIL break_status got=%h exp=%h", got, 16'h0101); end
        access(24'h3b00, 1'b1, got);
`endif
        scan(8'h23);
        access(24'h3b00, 1'b0, got);
        total++;
        if (got !== 16'hFF44) begin bad++; $display("FAIL after_break_key got=%h exp=%h", got, 16'hFF44); end
    endtask

    task automatic test_overflow();
        logic [15:0] got;
        logic [7:0]  codes [9];
        logic [15:0] exp   [8];
        codes = '{8'h1B, 8'h1C, 8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h1D, 8'h23, 8'h1D};
        exp   = '{16'hFF53, 16'hFF41, 16'hFF57, 16'hFF44, 16'hFF53, 16'hFF41, 16'hFF57, 16'hFF44};
        apply_reset();
        for (int i = 0; i < 9; i++) scan(codes[i]);
        access(24'h3b01, 1'b1, got);
        total++;
        if (got !== 16'h0807) begin bad++; $display("FAIL ovf_status got=%h exp=%h", got, 16'h0807); end
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0803) begin bad++; $display("FAIL ovf_cleared got=%h exp=%h", got, 16'h0803); end
        for (int i = 0; i < 8; i++) begin
            access(24'h3b00, 1'b1, got);
            total++;
            if (got !== exp[i]) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, got, exp[i]); end
        end
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL ovf_drained got=%h exp=%h", got, 16'h0000); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        logic [7:0]  codes [8];
        logic [15:0] exp   [8];
        codes = '{8'h1B, 8'h1C, 8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h1D, 8'h23};
        exp   = '{16'hFF41, 16'hFF57, 16'hFF44, 16'hFF53, 16'hFF41, 16'hFF57, 16'hFF44, 16'hFF57};
        apply_reset();
        for (int i = 0; i < 8; i++) scan(codes[i]);
        @(negedge clk);
        scan_code = 8'h1D;
        scan_valid = 1'b1;
        core_to_mem_address = 24'h3b00;
        core_to_mem_read_enable = 1'b1;
        #1 got = mem_to_core_data;
        @(posedge clk);
        #1 begin scan_valid = 1'b0; core_to_mem_read_enable = 1'b0; end
        total++;
        if (got !== 16'hFF53) begin bad++; $display("FAIL b2b_head got=%h exp=%h", got, 16'hFF53); end
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0803) begin bad++; $display("FAIL b2b_status got=%h exp=%h", got, 16'h0803); end
        for (int i = 0; i < 8; i++) begin
            access(24'h3b00, 1'b1, got);
            total++;
            if (got !== exp[i]) begin bad++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, got, exp[i]); end
        end
    endtask

    task automatic test_write();
        logic [15:0] got;
        apply_reset();
        @(negedge clk);
        core_to_mem_address = 24'h3b00;
        core_to_mem_data = 16'h1234;
        core_to_mem_write_enable = 1'b1;
        #1;
        total++;
        if (mem_to_ram_write_enable !== 1'b0) begin bad++; $display("FAIL mmio_write_we got=%b exp=0", mem_to_ram_write_enable); end
        @(negedge clk);
        core_to_mem_address = 24'h000010;
        #1;
        total++;
        if (mem_to_ram_write_enable !== 1'b1 || mem_to_ram_address !== 24'h000010 || mem_to_ram_data !== 16'h1234) begin
            bad++;
            $display("FAIL ram_write got=%b/%h/%h exp=1/000010/1234", mem_to_ram_write_enable, mem_to_ram_address, mem_to_ram_data);
        end
        @(posedge clk);
        #1 core_to_mem_write_enable = 1'b0;
        access(24'h000010, 1'b1, got);
        total++;
        if (got !== 16'h1234) begin bad++; $display("FAIL ram_read got=%h exp=%h", got, 16'h1234); end
        total++;
        if (ram_model[0] !== 16'h0000) begin bad++; $display("FAIL mmio_write_leak got=%h exp=%h", ram_model[0], 16'h0000); end
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL write_status got=%h exp=%h", got, 16'h0000); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        apply_reset();
        scan(8'hE0); scan(8'hF0);
        apply_reset();
        scan(8'h75);
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL mid_reset_status got=%h exp=%h", got, 16'h0000); end
        scan(8'h1D);
        access(24'h3b00, 1'b0, got);
        total++;
        if (got !== 16'hFF57) begin bad++; $display("FAIL mid_reset_key got=%h exp=%h", got, 16'hFF57); end
        access(24'h3b01, 1'b0, got);
        total++;
        if (got !== 16'h0101) begin bad++; $display("FAIL mid_reset_count got=%h exp=%h", got, 16'h0101); end
    endtask

    initial begin
        rst_n = 1'b0;
        scan_code = 8'h00;
        scan_valid = 1'b0;
        core_to_mem_data = 16'h0000;
        core_to_mem_address = 24'h000000;
        core_to_mem_write_enable = 1'b0;
        core_to_mem_read_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_extended();
        test_overflow();
        test_back_to_back();
        test_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
